// File: rtl/button_event_sched.sv
// button_event_sched: shared ms tick, per-button hold FSMs, round-robin
// arbitration of press events into a FIFO with a valid/ready head.
module button_event_sched #(
    parameter int N_BTN       = 4,
    parameter int TICK_DIV    = 1000,
    parameter int SHORT_TICKS = 50,
    parameter int LONG_TICKS  = 3000,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_btn,
    output logic                     evt_long,
    output logic                     evt_drop,
    output logic                     busy
);

    localparam int BW = $clog2(N_BTN);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HELD
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;

    state_t           r_state     [N_BTN];
    state_t           w_state_nxt [N_BTN];
    logic [CNT_W-1:0] r_cnt       [N_BTN];
    logic [CNT_W-1:0] w_cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] w_evt;
    logic [N_BTN-1:0] w_evt_long;
    logic [N_BTN-1:0] w_not_idle;

    logic [N_BTN-1:0] r_pend_v;
    logic [N_BTN-1:0] r_pend_long;
    logic [N_BTN-1:0] w_gnt_vec;
    logic [N_BTN-1:0] w_drop_vec;
    logic             w_gnt_any;
    logic [BW-1:0]    w_gnt_idx;
    logic [BW-1:0]    r_rr_ptr;

    logic [BW:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_push_ok;
    logic [AW:0]      w_cnt_after_pop;
    logic [AW-1:0]    w_rptr_nxt;
    logic [BW:0]      w_push_data;
    logic [BW:0]      w_head_nxt;
    logic             w_valid_nxt;

    logic             r_evt_valid;
    logic [BW-1:0]    r_evt_btn;
    logic             r_evt_long;
    logic             r_drop;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    // Shared timebase: free-running divider, wraps on the tick cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Per-button hold FSM state and counter registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Hold FSM next state; events fire only on tick cycles.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_evt[i]       = 1'b0;
            w_evt_long[i]  = 1'b0;
            w_not_idle[i]  = (r_state[i] != ST_IDLE);
            if (w_tick) begin
                unique case (r_state[i])
                    ST_IDLE: begin
                        if (r_sync2[i]) begin
                            w_cnt_nxt[i]   = CNT_W'(1);
                            w_state_nxt[i] = ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                            if (r_cnt[i] >= CNT_W'(SHORT_TICKS)) begin
                                w_evt[i] = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                            if (w_cnt_nxt[i] == CNT_W'(LONG_TICKS)) begin
                                w_evt[i]       = 1'b1;
                                w_evt_long[i]  = 1'b1;
                                w_state_nxt[i] = ST_HELD;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = r_evt_valid & evt_ready;
    assign w_push_ok = ~w_full | w_pop;

    // Round-robin grant: first pending slot at or above rr_ptr.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_vec = '0;
        if (w_push_ok) begin
            for (int k = 0; k < N_BTN; k++) begin
                v_idx = (int'(r_rr_ptr) + k) % N_BTN;
                if (!w_gnt_any && r_pend_v[v_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = BW'(v_idx);
                end
            end
        end
        if (w_gnt_any) begin
            w_gnt_vec[w_gnt_idx] = 1'b1;
        end
    end

    // A slot being granted this cycle can take a new event without loss.
    assign w_drop_vec = w_evt & r_pend_v & ~w_gnt_vec;

    // Pending slots, round-robin pointer and drop pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_v    <= '0;
            r_pend_long <= '0;
            r_rr_ptr    <= '0;
            r_drop      <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_evt[i] && !w_drop_vec[i]) begin
                    r_pend_v[i]    <= 1'b1;
                    r_pend_long[i] <= w_evt_long[i];
                end else if (w_gnt_vec[i]) begin
                    r_pend_v[i] <= 1'b0;
                end
            end
            if (w_gnt_any) begin
                if (w_gnt_idx == BW'(N_BTN - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_gnt_idx + BW'(1);
                end
            end
            r_drop <= |w_drop_vec;
        end
    end

    assign w_push          = w_gnt_any;
    assign w_push_data     = {w_gnt_idx, r_pend_long[w_gnt_idx]};
    assign w_cnt_after_pop = r_count - (AW+1)'(w_pop);
    assign w_rptr_nxt      = r_rptr + AW'(w_pop);
    assign w_valid_nxt     = (w_cnt_after_pop != '0) | w_push;

    // Next head: bypass the push data when the FIFO drains to it.
    always_comb begin
        w_head_nxt = '0;
        if (w_push && (w_cnt_after_pop == '0)) begin
            w_head_nxt = w_push_data;
        end else if (w_valid_nxt) begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // Event FIFO storage, pointers and registered head outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                r_mem[j] <= '0;
            end
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_btn   <= '0;
            r_evt_long  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_cnt_after_pop + (AW+1)'(w_push);
            r_evt_valid <= w_valid_nxt;
            r_evt_btn   <= w_head_nxt[BW:1];
            r_evt_long  <= w_head_nxt[0];
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_btn   = r_evt_btn;
    assign evt_long  = r_evt_long;
    assign evt_drop  = r_drop;
    assign busy      = (|w_not_idle) | (|r_pend_v) | (r_count != '0);

endmodule
